// File: rtl/n64_pi_master.sv
// N64 parallel-interface bus master: turns one request into a multiplexed
// address/strobe cycle on the cartridge AD bus.
module n64_pi_master #(
  parameter int unsigned T_ALE = 4,
  parameter int unsigned T_STB = 8,
  parameter int unsigned T_GAP = 2
) (
  input  logic        CLK1,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [31:0] REQ_ADDR,
  input  logic [15:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [15:0] RSP_RDATA,
  output logic [15:0] N64_AD_OUT,
  output logic        N64_AD_OE,
  input  logic [15:0] N64_AD_IN,
  output logic        N64_ALE_H,
  output logic        N64_ALE_L,
  output logic        N64_READ_N,
  output logic        N64_WRITE_N
);

  localparam logic [7:0] ALE_LD = 8'(T_ALE - 1);
  localparam logic [7:0] STB_LD = 8'(T_STB - 1);
  localparam logic [7:0] GAP_LD = 8'(T_GAP - 1);

  typedef enum logic [2:0] {IDLE, ADDR_H, ADDR_L, STROBE, GAP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_ld;
  logic        accept;
  logic [31:0] addr_q, addr_sel;
  logic        wr_q, wr_sel;
  logic [15:0] wdata_q, wdata_sel;
  logic        last;

  always_comb begin
    accept    = (state == IDLE) && REQ_VALID;
    last      = (cnt == 8'd0);
    addr_sel  = accept ? REQ_ADDR  : addr_q;
    wr_sel    = accept ? REQ_WRITE : wr_q;
    wdata_sel = accept ? REQ_WDATA : wdata_q;
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADDR_H;
      ADDR_H:  if (last)   state_nxt = ADDR_L;
      ADDR_L:  if (last)   state_nxt = STROBE;
      STROBE:  if (last)   state_nxt = GAP;
      GAP:     if (last)   state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
    cnt_ld = 8'd0;
    case (state_nxt)
      ADDR_H, ADDR_L: cnt_ld = ALE_LD;
      STROBE:         cnt_ld = STB_LD;
      GAP:            cnt_ld = GAP_LD;
      default:        cnt_ld = 8'd0;
    endcase
  end

  // Request fields are data: captured at accept only, never reset.
  always_ff @(posedge CLK1) begin
    if (accept) begin
      addr_q  <= REQ_ADDR;
      wr_q    <= REQ_WRITE;
      wdata_q <= REQ_WDATA;
    end
  end

  always_ff @(posedge CLK1) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      REQ_READY   <= 1'b1;
      RSP_VALID   <= 1'b0;
      RSP_RDATA   <= 16'h0000;
      N64_AD_OUT  <= 16'h0000;
      N64_AD_OE   <= 1'b0;
      N64_ALE_H   <= 1'b0;
      N64_ALE_L   <= 1'b0;
      N64_READ_N  <= 1'b1;
      N64_WRITE_N <= 1'b1;
    end else begin
      state     <= state_nxt;
      REQ_READY <= (state_nxt == IDLE);
      RSP_VALID <= 1'b0;
      if (state_nxt != state)
        cnt <= cnt_ld;
      else if (cnt != 8'd0)
        cnt <= cnt - 8'd1;

      // The edge closing the final strobe cycle is where the target's data is valid.
      if (state == STROBE && last && !wr_q) begin
        RSP_RDATA <= N64_AD_IN;
        RSP_VALID <= 1'b1;
      end

      N64_AD_OUT  <= 16'h0000;
      N64_AD_OE   <= 1'b0;
      N64_ALE_H   <= 1'b0;
      N64_ALE_L   <= 1'b0;
      N64_READ_N  <= 1'b1;
      N64_WRITE_N <= 1'b1;
      case (state_nxt)
        ADDR_H: begin
          N64_ALE_H  <= 1'b1;
          N64_ALE_L  <= 1'b1;
          N64_AD_OE  <= 1'b1;
          N64_AD_OUT <= addr_sel[31:16];
        end
        ADDR_L: begin
          // Halfword bus: byte-select bit is always presented as zero.
          N64_ALE_L  <= 1'b1;
          N64_AD_OE  <= 1'b1;
          N64_AD_OUT <= {addr_sel[15:1], addr_sel[0] & 1'b0};
        end
        STROBE: begin
          if (wr_sel) begin
            N64_WRITE_N <= 1'b0;
            N64_AD_OE   <= 1'b1;
            N64_AD_OUT  <= wdata_sel;
          end else begin
            N64_READ_N  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_pi_master.sv
// Bench for n64_pi_master: two instances (default and minimum timing) checked
// every cycle against a transaction-position model of the bus cycle.
module tb_n64_pi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic [15:0] ad_out    [2];
  logic        ad_oe     [2];
  logic [15:0] ad_in     [2];
  logic        ale_h     [2];
  logic        ale_l     [2];
  logic        read_n    [2];
  logic        write_n   [2];

  n64_pi_master dut0 (
    .CLK1(clk), .RST(rst),
    .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]), .REQ_WRITE(req_write[0]),
    .REQ_ADDR(req_addr[0]), .REQ_WDATA(req_wdata[0]),
    .RSP_VALID(rsp_valid[0]), .RSP_RDATA(rsp_rdata[0]),
    .N64_AD_OUT(ad_out[0]), .N64_AD_OE(ad_oe[0]), .N64_AD_IN(ad_in[0]),
    .N64_ALE_H(ale_h[0]), .N64_ALE_L(ale_l[0]),
    .N64_READ_N(read_n[0]), .N64_WRITE_N(write_n[0])
  );

  n64_pi_master #(.T_ALE(1), .T_STB(1), .T_GAP(1)) dut1 (
    .CLK1(clk), .RST(rst),
    .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]), .REQ_WRITE(req_write[1]),
    .REQ_ADDR(req_addr[1]), .REQ_WDATA(req_wdata[1]),
    .RSP_VALID(rsp_valid[1]), .RSP_RDATA(rsp_rdata[1]),
    .N64_AD_OUT(ad_out[1]), .N64_AD_OE(ad_oe[1]), .N64_AD_IN(ad_in[1]),
    .N64_ALE_H(ale_h[1]), .N64_ALE_L(ale_l[1]),
    .N64_READ_N(read_n[1]), .N64_WRITE_N(write_n[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  int ta [2] = '{4, 1};
  int ts [2] = '{8, 1};
  int tg [2] = '{2, 1};

  // Model: k counts cycles since the accept edge (1 = first address cycle).
  bit          m_busy  [2];
  int          m_k     [2];
  bit          m_wr    [2];
  logic [31:0] m_addr  [2];
  logic [15:0] m_wdata [2];
  logic [15:0] m_rdata [2];
  bit          m_rsp   [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] exp_vec(input int d);
    logic        aleh, alel, rdn, wrn, oe;
    logic [15:0] ad;
    aleh = 0; alel = 0; rdn = 1; wrn = 1; oe = 0; ad = 16'h0;
    if (m_busy[d]) begin
      if (m_k[d] <= ta[d]) begin
        aleh = 1; alel = 1; oe = 1; ad = m_addr[d][31:16];
      end else if (m_k[d] <= 2*ta[d]) begin
        alel = 1; oe = 1; ad = m_addr[d][15:0] & 16'hFFFE;
      end else if (m_k[d] <= 2*ta[d] + ts[d]) begin
        if (m_wr[d]) begin
          wrn = 0; oe = 1; ad = m_wdata[d];
        end else begin
          rdn = 0;
        end
      end
    end
    return {!m_busy[d], m_rsp[d], m_rdata[d], ad, oe, aleh, alel, rdn, wrn};
  endfunction

  function automatic logic [38:0] got_vec(input int d);
    return {req_ready[d], rsp_valid[d], rsp_rdata[d], ad_out[d], ad_oe[d],
            ale_h[d], ale_l[d], read_n[d], write_n[d]};
  endfunction

  task automatic model_edge(input int d);
    if (rst) begin
      m_busy[d] = 0; m_rsp[d] = 0; m_rdata[d] = 16'h0;
    end else begin
      m_rsp[d] = 0;
      if (m_busy[d]) begin
        if (!m_wr[d] && m_k[d] == 2*ta[d] + ts[d]) begin
          m_rdata[d] = ad_in[d];
          m_rsp[d]   = 1;
        end
        if (m_k[d] == 2*ta[d] + ts[d] + tg[d]) m_busy[d] = 0;
        else m_k[d]++;
      end else if (req_valid[d]) begin
        m_busy[d]  = 1;
        m_k[d]     = 1;
        m_wr[d]    = req_write[d];
        m_addr[d]  = req_addr[d];
        m_wdata[d] = req_wdata[d];
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    chk($sformatf("%s.d0", tag), 64'(got_vec(0)), 64'(exp_vec(0)));
    chk($sformatf("%s.d1", tag), 64'(got_vec(1)), 64'(exp_vec(1)));
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (m_busy[d] && n < 100) begin
      step("drain");
      n++;
    end
  endtask

  task automatic issue(input int d, input bit wr, input logic [31:0] a, input logic [15:0] w);
    wait_idle(d);
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = w;
    req_valid[d] = 1;
    step("accept");
    req_valid[d] = 0;
  endtask

  task automatic measure(input int d, input string tag, input int exp);
    int n = 0;
    while (req_ready[d] !== 1'b1 && n < 100) begin
      step(tag);
      n++;
    end
    chk(tag, 64'(n), 64'(exp));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_write[d] = 0; req_addr[d] = 0; req_wdata[d] = 0; ad_in[d] = 0;
      m_busy[d] = 0; m_k[d] = 0; m_wr[d] = 0; m_addr[d] = 0; m_wdata[d] = 0;
      m_rdata[d] = 0; m_rsp[d] = 0;
    end
    rst = 1;
    step("reset");
    step("reset");
    chk("reset_ready", 64'(req_ready[0]), 64'd1);
    chk("reset_rdata", 64'(rsp_rdata[0]), 64'd0);
    rst = 0;

    // Default-timing read
    ad_in[0] = 16'hBEEF;
    issue(0, 0, 32'h1000_0402, 16'h0000);
    measure(0, "rd_lat", 18);
    chk("rd_data", 64'(rsp_rdata[0]), 64'hBEEF);

    // Write with odd byte address
    issue(0, 1, 32'h1000_0003, 16'h1234);
    measure(0, "wr_lat", 18);
    chk("wr_keeps_rdata", 64'(rsp_rdata[0]), 64'hBEEF);

    // Two reads with REQ_VALID held high
    wait_idle(0);
    req_write[0] = 0; req_addr[0] = 32'h0A0B_0C0E; req_valid[0] = 1;
    ad_in[0] = 16'h5A5A;
    step("b2b");
    measure(0, "b2b_lat1", 18);
    step("b2b");
    chk("b2b_acc2", 64'(req_ready[0]), 64'd0);
    req_valid[0] = 0;
    measure(0, "b2b_lat2", 18);

    // Reset during the third strobe cycle of a read, request offered under reset
    issue(0, 0, 32'h1FFF_FFFE, 16'h0000);
    for (int n = 0; n < 40 && m_k[0] != 2*ta[0] + 3; n++) step("to_strobe3");
    rst = 1;
    req_valid[0] = 1;
    step("rst_mid");
    chk("rst_readn", 64'(read_n[0]), 64'd1);
    chk("rst_oe", 64'(ad_oe[0]), 64'd0);
    chk("rst_ready", 64'(req_ready[0]), 64'd1);
    rst = 0;
    req_valid[0] = 0;
    repeat (25) step("post_rst");

    // Minimum timing instance
    ad_in[1] = 16'hA5C3;
    issue(1, 0, 32'h8765_4320, 16'h0000);
    measure(1, "t1_lat", 4);
    chk("t1_data", 64'(rsp_rdata[1]), 64'hA5C3);

    // Request fields churned while a write is in flight
    issue(0, 1, 32'h1234_5678, 16'hC0DE);
    repeat (17) begin
      req_valid[0] = 1'($urandom);
      req_write[0] = 1'($urandom);
      req_addr[0]  = $urandom;
      req_wdata[0] = 16'($urandom);
      step("churn");
    end
    req_valid[0] = 0;
    wait_idle(0);

    // Random traffic on both instances with occasional reset
    repeat (1500) begin
      for (int d = 0; d < 2; d++) begin
        req_valid[d] = ($urandom_range(0, 3) != 0);
        req_write[d] = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = 16'($urandom);
        ad_in[d]     = 16'($urandom);
      end
      rst = ($urandom_range(0, 99) == 0);
      step("rand");
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/n64_pi_master.md
N64_PI_MASTER -- requirements
Module: n64_pi_master

Interface
Parameters:
REQ-001 SHALL have parameter T_ALE, default 4, cycles each address phase (ALE high / ALE low) is held; legal range 1..255.
REQ-002 SHALL have parameter T_STB, default 8, cycles READ_N/WRITE_N is held low; legal range 1..255.
REQ-003 SHALL have parameter T_GAP, default 2, idle cycles after strobe before next request; legal range 1..255.

Ports:
REQ-004 SHALL have port CLK1  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port REQ_VALID  in  1  request present.
REQ-007 SHALL have port REQ_READY  out  1  block accepts request this cycle.
REQ-008 SHALL have port REQ_WRITE  in  1  1=write, 0=read.
REQ-009 SHALL have port REQ_ADDR  in  32  byte address, halfword-aligned.
REQ-010 SHALL have port REQ_WDATA  in  16  write data.
REQ-011 SHALL have port RSP_VALID  out  1  one-cycle pulse, read data valid.
REQ-012 SHALL have port RSP_RDATA  out  16  captured read data.
REQ-013 SHALL have port N64_AD_OUT  out  16  AD bus drive value.
REQ-014 SHALL have port N64_AD_OE  out  1  AD bus output enable (pad tristate control).
REQ-015 SHALL have port N64_AD_IN  in  16  AD bus sampled value.
REQ-016 SHALL have port N64_ALE_H  out  1  high-address latch enable.
REQ-017 SHALL have port N64_ALE_L  out  1  low-address latch enable.
REQ-018 SHALL have port N64_READ_N  out  1  read strobe, active-low.
REQ-019 SHALL have port N64_WRITE_N  out  1  write strobe, active-low.

Function
REQ-020 SHALL implement FSM states IDLE, ADDR_H, ADDR_L, STROBE, GAP; all bus outputs SHALL be registered.
REQ-021 SHALL assert REQ_READY only in IDLE; accept occurs on an edge with REQ_VALID=1 and REQ_READY=1; ADDR, WRITE and WDATA SHALL be latched at accept.
REQ-022 SHALL hold IDLE outputs: ALE_H=0, ALE_L=0, READ_N=1, WRITE_N=1, AD_OE=0, AD_OUT=0.
REQ-023 SHALL, in ADDR_H for T_ALE cycles: ALE_H=1, ALE_L=1, AD_OE=1, AD_OUT=addr[31:16].
REQ-024 SHALL, in ADDR_L for T_ALE cycles: ALE_H=0, ALE_L=1, AD_OE=1, AD_OUT={addr[15:1],1'b0} (bit 0 forced to 0).
REQ-025 SHALL, in STROBE for T_STB cycles: ALE_L=0; reads drive READ_N=0 with AD_OE=0; writes drive WRITE_N=0 with AD_OE=1 and AD_OUT=wdata.
REQ-026 SHALL, on reads, sample N64_AD_IN into RSP_RDATA on the edge that ends the last STROBE cycle, and assert RSP_VALID for exactly the first GAP cycle.
REQ-027 SHALL keep RSP_RDATA stable until the next read capture; writes SHALL never assert RSP_VALID.
REQ-028 SHALL, in GAP for T_GAP cycles, drive IDLE bus values, then enter IDLE.
REQ-029 SHALL use one phase counter, reloaded on each state entry, with no wrap between phases.
REQ-030 SHALL ignore REQ_VALID outside IDLE; request fields change mid-transaction SHALL have no effect.
REQ-031 SHALL take exactly 2*T_ALE+T_STB+T_GAP cycles from accept edge to REQ_READY=1 (18 with defaults); back-to-back requests SHALL have no extra dead cycle.
REQ-032 SHALL never assert READ_N=0 and WRITE_N=0 simultaneously, nor drive AD_OE=1 while READ_N=0.

Reset
REQ-033 SHALL, when RST=1 on any edge, including mid-transaction, enter IDLE with IDLE bus values, REQ_READY=1 the next cycle, RSP_VALID=0, RSP_RDATA=0, counter=0.
REQ-034 SHALL drop an in-flight transaction on reset with no RSP_VALID; a request presented while RST=1 SHALL NOT be accepted.

Verification
REQ-035 SHALL cover: read at defaults, ADDR=0x10000402, AD_IN=0xBEEF during strobe -> AD_OUT 0x1000 for 4 cycles, 0x0402 for 4 cycles, READ_N low 8 cycles, RSP_VALID one cycle with RSP_RDATA=0xBEEF, REQ_READY 18 cycles after accept.
REQ-036 SHALL cover: write ADDR=0x10000003, WDATA=0x1234 -> low phase AD_OUT=0x0002, WRITE_N low 8 cycles with AD_OUT=0x1234, AD_OE=1, no RSP_VALID.
REQ-037 SHALL cover: REQ_VALID held high with two queued reads -> second accept on the first IDLE cycle, periods exactly 18 cycles, AD_OE=0 throughout both strobes.
REQ-038 SHALL cover: RST pulsed during 3rd STROBE cycle of a read -> next cycle READ_N=1, AD_OE=0, REQ_READY=1, no RSP_VALID ever.
REQ-039 SHALL cover: T_ALE=1, T_STB=1, T_GAP=1 -> read completes in 4 cycles, RSP_VALID in the cycle after the single strobe cycle.
REQ-040 SHALL cover: REQ fields toggled mid-transaction -> bus values match fields latched at accept.
